// File: rtl/top_if_pkg.sv
// Shared constants and types for the interface adder slice: default operand
// width and the registered-path operation encoding.
package top_if_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

endpackage

// File: rtl/top_if_alu.sv
// Combinational datapath: sum, borrow-extended difference and accumulate.
// All results are WIDTH+1 bits wide; the top bit is carry, borrow or acc MSB.
module top_if_alu #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   acc,
  output logic [WIDTH:0]   add_res,
  output logic [WIDTH:0]   sub_res,
  output logic [WIDTH:0]   acc_res
);

  assign add_res = {1'b0, a} + {1'b0, b};
  // Subtracting zero-extended operands leaves the borrow in bit WIDTH.
  assign sub_res = {1'b0, a} - {1'b0, b};
  assign acc_res = acc + {1'b0, a};

endmodule

// File: rtl/top_if_adder.sv
// Adder with a free-running combinational sum and a one-deep registered
// ADD/SUB/ACC/CLR path behind a valid/ready handshake.
module top_if_adder
  import top_if_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   c,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero,
  output logic [7:0]       txn_count
);

  logic [WIDTH:0] acc;
  logic [WIDTH:0] add_res, sub_res, acc_res;
  logic [WIDTH:0] nxt_res, nxt_acc;
  logic           accept;

  top_if_alu #(.WIDTH(WIDTH)) u_alu (
    .a       (a),
    .b       (b),
    .acc     (acc),
    .add_res (add_res),
    .sub_res (sub_res),
    .acc_res (acc_res)
  );

  assign c        = add_res;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign zero     = (res == '0);

  always_comb begin
    nxt_res = add_res;
    nxt_acc = acc;
    unique case (op_e'(op))
      OP_ADD: nxt_res = add_res;
      OP_SUB: nxt_res = sub_res;
      OP_ACC: begin
        nxt_res = acc_res;
        nxt_acc = acc_res;
      end
      OP_CLR: begin
        nxt_res = '0;
        nxt_acc = '0;
      end
      default: nxt_res = add_res;
    endcase
  end

  // Output stage: reload on accept, otherwise drain when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res       <= nxt_res;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      txn_count <= '0;
    end else if (accept) begin
      acc       <= nxt_acc;
      txn_count <= txn_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_top_if_adder.sv
// Self-checking bench for top_if_adder: directed vector table, backpressure,
// async reset and counter wrap sequences, then random traffic against a model.
module tb_top_if_adder;
  import top_if_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W:0]   c;
  logic [1:0]   op = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   res;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         zero;
  logic [7:0]   txn_count;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference state
  int m_acc = 0;
  int m_res = 0;
  int m_ov  = 0;
  int m_txn = 0;

  top_if_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero      (zero),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_e  vop;
    int   va;
    int   vb;
    int   exp_res;
    bit   exp_zero;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Behavioural result of one accepted request; updates the model accumulator.
  function automatic int model_op(input int mop, input int ma, input int mb);
    int r;
    case (mop)
      0: r = ma + mb;
      1: r = ((ma - mb + 16) % 16) + ((ma < mb) ? 16 : 0);
      2: begin m_acc = (m_acc + ma) % 32; r = m_acc; end
      default: begin m_acc = 0; r = 0; end
    endcase
    return r;
  endfunction

  // One request with out_ready=1; checks the registered result a cycle later.
  task automatic do_req(input op_e rop, input int ra, input int rb, input int er, input bit ez,
                        input string tag);
    int mr;
    op = rop; a = W'(ra); b = W'(rb); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    mr = model_op(int'(rop), ra, rb);
    m_txn = (m_txn + 1) % 256;
    in_valid = 1'b0;
    chk({tag, " out_valid"}, int'(out_valid), 1);
    chk({tag, " res"}, int'(res), er);
    chk({tag, " zero"}, int'(zero), int'(ez));
    chk({tag, " txn"}, int'(txn_count), m_txn);
    if (mr != er) $display("note: table entry %s disagrees with model (%0d)", tag, mr);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    m_acc = 0; m_ov = 0; m_txn = 0; m_res = 0;
  endtask

  initial begin
    vec_t vecs[$];
    int   snap;
    bit   iv, ordy;
    int   rop, ra, rb;
    bit   acc_now;

    // Reset state and combinational sum during reset
    #2;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst res", int'(res), 0);
    chk("rst zero", int'(zero), 1);
    chk("rst in_ready", int'(in_ready), 1);
    chk("rst txn", int'(txn_count), 0);
    a = 4'd5; b = 4'd5; #0; #1;
    chk("comb 5+5", int'(c), 10);
    a = 4'd15; b = 4'd15; #1;
    chk("comb 15+15", int'(c), 30);

    // Release between edges; first edge after release accepts
    @(posedge clk); #1;
    rst_n = 1'b1;

    vecs = '{
      '{OP_ADD, 9, 8, 17, 1'b0},
      '{OP_SUB, 3, 5, 30, 1'b0},
      '{OP_SUB, 5, 5, 0,  1'b1},
      '{OP_CLR, 7, 2, 0,  1'b1},
      '{OP_ACC, 15, 0, 15, 1'b0},
      '{OP_ACC, 15, 9, 30, 1'b0},
      '{OP_ACC, 15, 3, 13, 1'b0},
      '{OP_ADD, 1, 1, 2,  1'b0},
      '{OP_ACC, 2, 0, 15, 1'b0},
      '{OP_CLR, 0, 0, 0,  1'b1},
      '{OP_ADD, 15, 15, 30, 1'b0},
      '{OP_SUB, 0, 15, 17, 1'b0}
    };
    for (int i = 0; i < vecs.size(); i++)
      do_req(vecs[i].vop, vecs[i].va, vecs[i].vb, vecs[i].exp_res, vecs[i].exp_zero,
             $sformatf("vec%0d", i));

    // Drain: no accept with out_ready=1 drops out_valid
    @(posedge clk); #1;
    chk("drain out_valid", int'(out_valid), 0);

    // Backpressure: stall five cycles, then drain and accept on the same edge
    op = OP_ADD; a = 4'd6; b = 4'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    m_txn++;
    chk("bp first res", int'(res), 13);
    a = 4'd2; b = 4'd9; op = OP_SUB;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp in_ready c%0d", k), int'(in_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("bp res hold c%0d", k), int'(res), 13);
      chk($sformatf("bp valid hold c%0d", k), int'(out_valid), 1);
    end
    chk("bp txn no accept", int'(txn_count), m_txn);
    op = OP_ADD; a = 4'd1; b = 4'd2; out_ready = 1'b1; #1;
    chk("bp release in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    m_txn++;
    in_valid = 1'b0;
    chk("bp swap res", int'(res), 3);
    chk("bp swap out_valid", int'(out_valid), 1);
    chk("bp swap txn", int'(txn_count), m_txn);

    // Async reset mid-cycle with a pending result
    op = OP_ACC; a = 4'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("ar pre out_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0; #1;
    chk("ar out_valid", int'(out_valid), 0);
    chk("ar res", int'(res), 0);
    chk("ar txn", int'(txn_count), 0);
    chk("ar zero", int'(zero), 1);
    chk("ar in_ready", int'(in_ready), 1);
    a = 4'd11; b = 4'd6; #1;
    chk("ar comb", int'(c), 17);
    rst_n = 1'b1;
    m_acc = 0; m_ov = 0; m_txn = 0;
    // Accumulator cleared by reset: first ACC returns the operand itself
    do_req(OP_ACC, 3, 0, 3, 1'b0, "post-reset acc");

    // Counter wrap
    apply_reset();
    op = OP_ADD; a = 4'd1; b = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    chk("wrap 256", int'(txn_count), 0);
    @(posedge clk); #1;
    chk("wrap 257", int'(txn_count), 1);
    in_valid = 1'b0;
    apply_reset();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      rop  = $urandom_range(0, 3);
      ra   = $urandom_range(0, 15);
      rb   = $urandom_range(0, 15);
      in_valid = iv; out_ready = ordy; op = rop[1:0]; a = W'(ra); b = W'(rb);
      #1;
      chk($sformatf("rnd%0d in_ready", n), int'(in_ready), (m_ov == 0 || ordy) ? 1 : 0);
      chk($sformatf("rnd%0d c", n), int'(c), ra + rb);
      acc_now = iv && (m_ov == 0 || ordy);
      @(posedge clk); #1;
      if (acc_now) begin
        m_res = model_op(rop, ra, rb);
        m_ov  = 1;
        m_txn = (m_txn + 1) % 256;
      end else if (ordy) begin
        m_ov = 0;
      end
      chk($sformatf("rnd%0d out_valid", n), int'(out_valid), m_ov);
      chk($sformatf("rnd%0d txn", n), int'(txn_count), m_txn);
      if (m_ov != 0) begin
        chk($sformatf("rnd%0d res", n), int'(res), m_res);
        chk($sformatf("rnd%0d zero", n), int'(zero), (m_res == 0) ? 1 : 0);
      end
    end
    snap = chk_cnt;
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, snap);
    $finish;
  end

endmodule
